// File: rtl/lc3_wb_pkg.sv
// Shared types and constants for the LC3 writeback stage and register file.
package lc3_wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC,
        WB_ILLEGAL
    } wb_sel_e;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

endpackage

// File: rtl/writeback_nzp_calc.sv
// Combinational {N,Z,P} condition-code generator; exactly one bit is set for any input.
module writeback_nzp_calc
    import lc3_wb_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data,
    output logic [2:0]        nzp
);

    always_comb begin
        nzp = NZP_P;
        if (data[DATA_W-1]) begin
            nzp = NZP_N;
        end else if (data == '0) begin
            nzp = NZP_Z;
        end
    end

endmodule

// File: rtl/writeback_regfile_multi.sv
// LC3 writeback stage with register file, NUM_RD registered read ports, NZP psr and sticky
// illegal-select flag. Define LC3_WB_BYPASS_EN to forward a same-edge write onto matching read ports.
module writeback_regfile_multi
    import lc3_wb_pkg::*;
#(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 8,
    parameter int  NUM_RD   = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_writeback,
    input  logic [1:0]               W_Control,
    input  logic [DATA_W-1:0]        aluout,
    input  logic [DATA_W-1:0]        memout,
    input  logic [DATA_W-1:0]        pcout,
    input  logic [AW-1:0]            dr,
    input  logic [NUM_RD*AW-1:0]     sr,
    output logic [NUM_RD*DATA_W-1:0] vsr,
    output logic [2:0]               psr,
    output logic                     wb_err
);

    wb_sel_e                     sel;
    logic [DATA_W-1:0]           wb_data;
    logic [2:0]                  wb_nzp;
    logic                        wr_en;

    logic [DATA_W-1:0]           rf_q [NUM_REGS];
    logic [DATA_W-1:0]           rf_d [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0]    vsr_q;
    logic [NUM_RD*DATA_W-1:0]    vsr_d;
    logic [2:0]                  psr_q;
    logic [2:0]                  psr_d;
    logic                        err_q;
    logic                        err_d;
    logic [AW-1:0]               rd_addr [NUM_RD];

    assign sel = wb_sel_e'(W_Control);

    always_comb begin
        wb_data = aluout;
        case (sel)
            WB_ALU:  wb_data = aluout;
            WB_MEM:  wb_data = memout;
            WB_PC:   wb_data = pcout;
            default: wb_data = aluout;
        endcase
    end

    writeback_nzp_calc #(.DATA_W(DATA_W)) u_nzp (
        .data (wb_data),
        .nzp  (wb_nzp)
    );

    assign wr_en = enable_writeback && (sel != WB_ILLEGAL);

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_addr
        assign rd_addr[g] = sr[g*AW +: AW];
    end

    always_comb begin
        rf_d  = rf_q;
        psr_d = psr_q;
        err_d = err_q;
        if (wr_en) begin
            rf_d[dr] = wb_data;
            psr_d    = wb_nzp;
        end
        if (enable_writeback && (sel == WB_ILLEGAL)) begin
            err_d = 1'b1;
        end
    end

    // Reads sample the pre-edge array; the bypass build overrides with the incoming write.
    always_comb begin
        vsr_d = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            vsr_d[i*DATA_W +: DATA_W] = rf_q[rd_addr[i]];
`ifdef LC3_WB_BYPASS_EN
            if (wr_en && (dr == rd_addr[i])) begin
                vsr_d[i*DATA_W +: DATA_W] = wb_data;
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            vsr_q <= '0;
            psr_q <= '0;
            err_q <= 1'b0;
        end else begin
            rf_q  <= rf_d;
            vsr_q <= vsr_d;
            psr_q <= psr_d;
            err_q <= err_d;
        end
    end

    assign vsr    = vsr_q;
    assign psr    = psr_q;
    assign wb_err = err_q;

endmodule

// File: tb/tb_writeback_regfile_multi.sv
// Directed self-checking bench for writeback_regfile_multi: default 16-bit/8x2 instance plus a
// 32-bit/16x3 instance. Expected read-collision data follows LC3_WB_BYPASS_EN when defined.
module tb_writeback_regfile_multi;

    logic        clk = 1'b0;
    logic        rst;

    logic        en;
    logic [1:0]  wctl;
    logic [15:0] alu, mem, pc;
    logic [2:0]  dr;
    logic [5:0]  sr;
    logic [31:0] vsr;
    logic [2:0]  psr;
    logic        err;

    logic        en2;
    logic [1:0]  wctl2;
    logic [31:0] alu2, mem2, pc2;
    logic [3:0]  dr2;
    logic [11:0] sr2;
    logic [95:0] vsr2;
    logic [2:0]  psr2;
    logic        err2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback_regfile_multi dut (
        .clock            (clk),
        .reset            (rst),
        .enable_writeback (en),
        .W_Control        (wctl),
        .aluout           (alu),
        .memout           (mem),
        .pcout            (pc),
        .dr               (dr),
        .sr               (sr),
        .vsr              (vsr),
        .psr              (psr),
        .wb_err           (err)
    );

    writeback_regfile_multi #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) dut_wide (
        .clock            (clk),
        .reset            (rst),
        .enable_writeback (en2),
        .W_Control        (wctl2),
        .aluout           (alu2),
        .memout           (mem2),
        .pcout            (pc2),
        .dr               (dr2),
        .sr               (sr2),
        .vsr              (vsr2),
        .psr              (psr2),
        .wb_err           (err2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] w, input logic [15:0] d, input logic [2:0] r);
        en = 1'b1; wctl = w; dr = r;
        alu = 16'h0; mem = 16'h0; pc = 16'h0;
        case (w)
            2'd0:    alu = d;
            2'd1:    mem = d;
            default: pc  = d;
        endcase
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; wctl = 2'd0; alu = '0; mem = '0; pc = '0; dr = '0; sr = '0;
        en2 = 1'b0; wctl2 = 2'd0; alu2 = '0; mem2 = '0; pc2 = '0; dr2 = '0; sr2 = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("reset_psr", 64'(psr), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_vsr", 64'(vsr), 64'd0);

        for (int i = 0; i < 8; i++) begin
            sr = {3'(7 - i), 3'(i)};
            step();
            check("rf_init_p0", 64'(vsr[15:0]), 64'd0);
            check("rf_init_p1", 64'(vsr[31:16]), 64'd0);
        end

        wr(2'd0, 16'h8001, 3'd3);
        step();
        check("psr_neg", 64'(psr), 64'b100);
        en = 1'b0; sr = {3'd0, 3'd3};
        step();
        check("rd_r3", 64'(vsr[15:0]), 64'h8001);

        wr(2'd1, 16'h0000, 3'd1);
        step();
        check("psr_zero_mem", 64'(psr), 64'b010);
        wr(2'd2, 16'h0005, 3'd4);
        step();
        check("psr_pos_pc", 64'(psr), 64'b001);
        en = 1'b0; sr = {3'd4, 3'd1};
        step();
        check("rd_r1", 64'(vsr[15:0]), 64'h0000);
        check("rd_r4", 64'(vsr[31:16]), 64'h0005);

        wr(2'd0, 16'h00AA, 3'd5);
        step();
        wr(2'd0, 16'h1234, 3'd5);
        sr = {3'd5, 3'd5};
        step();
`ifdef LC3_WB_BYPASS_EN
        check("coll_p0", 64'(vsr[15:0]), 64'h1234);
        check("coll_p1", 64'(vsr[31:16]), 64'h1234);
`else
        check("coll_p0", 64'(vsr[15:0]), 64'h00AA);
        check("coll_p1", 64'(vsr[31:16]), 64'h00AA);
`endif
        en = 1'b0;
        step();
        check("coll_next_p0", 64'(vsr[15:0]), 64'h1234);
        check("coll_next_p1", 64'(vsr[31:16]), 64'h1234);

        wr(2'd0, 16'h0007, 3'd6);
        step();
        check("b2b_psr1", 64'(psr), 64'b001);
        wr(2'd0, 16'hFFF0, 3'd6);
        step();
        check("b2b_psr2", 64'(psr), 64'b100);
        en = 1'b0; sr = {3'd6, 3'd6};
        step();
        check("b2b_last", 64'(vsr[15:0]), 64'hFFF0);

        wr(2'd0, 16'h0010, 3'd2);
        step();
        en = 1'b0; wctl = 2'd0; alu = 16'hFFFF; dr = 3'd2;
        step();
        check("hold_psr", 64'(psr), 64'b001);
        wctl = 2'd3;
        step();
        check("hold_no_err", 64'(err), 64'd0);
        sr = {3'd0, 3'd2};
        step();
        check("hold_r2", 64'(vsr[15:0]), 64'h0010);

        en = 1'b1; wctl = 2'd3; alu = 16'h0000; dr = 3'd2;
        step();
        check("illegal_err", 64'(err), 64'd1);
        check("illegal_psr", 64'(psr), 64'b001);
        wr(2'd0, 16'h0020, 3'd7);
        step();
        check("illegal_r2", 64'(vsr[15:0]), 64'h0010);
        check("err_sticky", 64'(err), 64'd1);
        en = 1'b0; sr = {3'd0, 3'd7};
        step();
        check("rd_r7", 64'(vsr[15:0]), 64'h0020);

        en2 = 1'b1; wctl2 = 2'd0; alu2 = 32'h8000_0000; dr2 = 4'd15; sr2 = {4'd15, 4'd15, 4'd15};
        step();
        check("wide_psr", 64'(psr2), 64'b100);
        en2 = 1'b0;
        step();
        check("wide_p0", 64'(vsr2[31:0]), 64'h8000_0000);
        check("wide_p1", 64'(vsr2[63:32]), 64'h8000_0000);
        check("wide_p2", 64'(vsr2[95:64]), 64'h8000_0000);

        wr(2'd0, 16'h1111, 3'd0);
        sr = {3'd7, 3'd7};
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_vsr", 64'(vsr), 64'd0);
        check("rst_async_psr", 64'(psr), 64'd0);
        check("rst_async_err", 64'(err), 64'd0);
        step();
        en = 1'b0;
        rst = 1'b0;
        sr = {3'd7, 3'd0};
        step();
        check("rst_r0", 64'(vsr[15:0]), 64'd0);
        check("rst_r7", 64'(vsr[31:16]), 64'd0);
        check("rst_err2", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
